ppa_arbiter: RTL and testbench
==============================

# ppa_arbiter

Round-robin controller that shares one combinational 16-bit parallel-prefix adder among `NREQ` requesters in the FIR datapath. It accepts operand triples over per-requester valid/ready handshakes, drives the shared adder from registered operands, and returns the captured sum and carry with the requester ID over a single valid/ready response channel. The adder sits outside this block and connects through the `ppa_*` ports.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, `$clog2(NREQ)`: requester ID width. Derived; do not override.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: request valid, one bit per requester.
- `req_ready` out NREQ: grant/accept; at most one bit high.
- `req_add_1` in NREQ*16: operand A; requester i uses bits [16i+15:16i].
- `req_add_2` in NREQ*16: operand B, same packing as `req_add_1`.
- `req_c_in` in NREQ: carry-in, one bit per requester.
- `req_lock` in NREQ: carry-chain lock request. Ignored unless `PPA_ARB_LOCK_EN` is defined.
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: result consumed.
- `rsp_id` out IDW: index of the requester that owns the result.
- `rsp_sum` out 16: captured sum.
- `rsp_c_out` out 1: captured carry-out.
- `ppa_add_1`, `ppa_add_2` out 16: operands driven to the shared adder.
- `ppa_c_in` out 1: carry-in driven to the shared adder.
- `ppa_sum` in 16, `ppa_c_out` in 1: adder results.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - `req_ready` is a combinational function of `req_valid`, `ptr`, and the lock state.
  - The grant goes to the first valid requester scanning `ptr+1, ptr+2, …` modulo NREQ.
  - On handshake (`req_valid[g] & req_ready[g]`), the block registers operands `op_a`, `op_b`, `op_c` and ID `g`, sets `ptr <= g`, and moves to EXEC.
- **EXEC**
  - `ppa_add_1/ppa_add_2/ppa_c_in` are driven only from `op_a/op_b/op_c`, which holds the adder inputs stable for one full cycle.
  - At the end of the cycle the block captures `ppa_sum` and `ppa_c_out` into `rsp_sum` and `rsp_c_out`, sets `rsp_valid <= 1`, and moves to RESP.
- **RESP**
  - `rsp_*` are held stable and `req_ready` is all-zero.
  - On `rsp_valid & rsp_ready` the block clears `rsp_valid` and returns to IDLE.
- Arithmetic: `{rsp_c_out, rsp_sum} = op_a + op_b + op_c`, a 17-bit result with no truncation. The block never checks or alters the adder output.
- Requester inputs are sampled only at the handshake edge. Changes after that edge have no effect on the operation in flight.
- Reset, at any time including mid-EXEC or mid-RESP:
  - state goes to IDLE and `ptr` to NREQ-1, so requester 0 wins first;
  - `rsp_valid`, `rsp_id`, `rsp_sum`, `rsp_c_out`, the operand registers, and the `ppa_*` outputs go to 0;
  - lock is cleared and any in-flight operation is dropped without a response.
- The block never reorders or drops accepted requests outside of reset.

## Timing
- Request accepted at edge k: `rsp_valid` is high after edge k+1, so latency from acceptance to result is 1 cycle.
- Response consumed at edge m: the earliest next `req_ready` is in the cycle after m, and the earliest next acceptance is at edge m+1.
- Peak throughput: one operation per 3 cycles.
- Timing path: operand register → adder → `rsp_sum` register, one full clock period. The target period is 5 ns.
- No combinational path from `rsp_ready` to any output.

## Configuration
- `PPA_ARB_LOCK_EN` defined (multi-word chaining):
  - If an accepted request has `req_lock[g]=1`, the arbiter enters a locked state once the response is consumed.
  - While locked, only requester g can be granted in IDLE; other requesters stall regardless of `ptr`.
  - The next operation from g uses the stored `rsp_c_out` of the previous operation as `op_c`, and ignores `req_c_in[g]`.
  - Accepting an operation with `req_lock[g]=0` ends the chain; that operation still uses the chained carry.
  - `ptr` advances normally.
- `PPA_ARB_LOCK_EN` undefined: `req_lock` is ignored, `op_c` always equals `req_c_in[g]`, and no lock state is synthesized.

## Test plan
- **Single requester, directed sums.** Apply these to requester 1:
  - 4322+7656, c_in 1 → sum 11979, c_out 0, id 1;
  - 987+71, c_in 0 → sum 1058;
  - 65534+1, c_in 0 → sum 65535, c_out 0;
  - 65534+1, c_in 1 → sum 0, c_out 1.
- **Round robin.** All four `req_valid` held high with `rsp_ready=1` → grant order 0,1,2,3,0. No requester is granted twice while another waits.
- **Backpressure.** `rsp_ready` held low for 5 cycles after `rsp_valid` → `rsp_*` stay constant, `req_ready=0` throughout, and the next grant comes the cycle after the handshake.
- **Reset mid-operation.** Assert `rst_n=0` during EXEC → all outputs go to 0 immediately (async) and no response appears. After release, requester 0 wins a simultaneous 0/2 request.
- **Lock chain (`PPA_ARB_LOCK_EN`).** Requester 2 sends 0xFFFF+0x0001 with lock=1 → sum 0x0000, c_out 1. Requester 0 is valid meanwhile but not granted. Requester 2 then sends 0x0001+0x0000 with lock=0 and `req_c_in=0` → sum 0x0002, and requester 0 is granted next.

Source files
------------

// File: rtl/ppa_arbiter.sv
// rtl/ppa_arbiter.sv - round-robin arbiter sharing one external 16-bit prefix adder among NREQ requesters
// Optional multi-word carry chaining is enabled by defining PPA_ARB_LOCK_EN.
module ppa_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*16-1:0] req_add_1,
    input  logic [NREQ*16-1:0] req_add_2,
    input  logic [NREQ-1:0]   req_c_in,
    input  logic [NREQ-1:0]   req_lock,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_sum,
    output logic              rsp_c_out,
    output logic [15:0]       ppa_add_1,
    output logic [15:0]       ppa_add_2,
    output logic              ppa_c_in,
    input  logic [15:0]       ppa_sum,
    input  logic              ppa_c_out
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [15:0]     op_a;
    logic [15:0]     op_b;
    logic            op_c;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant_vec;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  idx;
    logic            grant_found;
    logic            next_c;

`ifdef PPA_ARB_LOCK_EN
    logic lock_active;
    logic lock_pend;

    // While chained, only the owner of the previous result (still held in rsp_id) may be granted.
    always_comb begin
        eligible = req_valid;
        if (lock_active) begin
            eligible = req_valid & (NREQ'(1) << rsp_id);
        end
    end

    assign next_c = lock_active ? rsp_c_out : req_c_in[grant_id];
`else
    logic unused_lock;

    assign unused_lock = ^req_lock;
    assign eligible    = req_valid;
    assign next_c      = req_c_in[grant_id];
`endif

    always_comb begin
        grant_vec   = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        idx         = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + 1 + k) % NREQ);
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
        if (state == IDLE && grant_found) begin
            grant_vec[grant_id] = 1'b1;
        end
    end

    assign req_ready = grant_vec;
    assign ppa_add_1 = op_a;
    assign ppa_add_2 = op_b;
    assign ppa_c_in  = op_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= IDW'(NREQ - 1);
            op_a      <= '0;
            op_b      <= '0;
            op_c      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_c_out <= 1'b0;
`ifdef PPA_ARB_LOCK_EN
            lock_active <= 1'b0;
            lock_pend   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        op_a   <= req_add_1[16*grant_id +: 16];
                        op_b   <= req_add_2[16*grant_id +: 16];
                        op_c   <= next_c;
                        rsp_id <= grant_id;
                        ptr    <= grant_id;
                        state  <= EXEC;
`ifdef PPA_ARB_LOCK_EN
                        lock_pend <= req_lock[grant_id];
`endif
                    end
                end
                EXEC: begin
                    rsp_sum   <= ppa_sum;
                    rsp_c_out <= ppa_c_out;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
`ifdef PPA_ARB_LOCK_EN
                        lock_active <= lock_pend;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ppa_arbiter.sv
// tb/tb_ppa_arbiter.sv - scoreboard bench for ppa_arbiter with a behavioural arbitration/sum model
module tb_ppa_arbiter;

    localparam int NREQ = 4;

    typedef struct {
        int          id;
        logic [16:0] res;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   v;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*16-1:0] add1;
    logic [NREQ*16-1:0] add2;
    logic [NREQ-1:0]   cin;
    logic [NREQ-1:0]   lk;
    logic              rsp_valid;
    logic              rr;
    logic [1:0]        rsp_id;
    logic [15:0]       rsp_sum;
    logic              rsp_c_out;
    logic [15:0]       ppa_add_1;
    logic [15:0]       ppa_add_2;
    logic              ppa_c_in;
    logic [15:0]       ppa_sum;
    logic              ppa_c_out;
    logic [15:0]       a [NREQ];
    logic [15:0]       b [NREQ];

    int   n_cmp = 0;
    int   n_err = 0;
    int   m_ptr = NREQ - 1;
    bit   busy = 0;
    bit   m_locked = 0;
    bit   m_lock_pend = 0;
    bit   m_last_cout = 0;
    int   m_owner = 0;
    int   grant_log[$];
    exp_t exp_q[$];

    ppa_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v), .req_ready(req_ready),
        .req_add_1(add1), .req_add_2(add2),
        .req_c_in(cin), .req_lock(lk),
        .rsp_valid(rsp_valid), .rsp_ready(rr),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_c_out(rsp_c_out),
        .ppa_add_1(ppa_add_1), .ppa_add_2(ppa_add_2), .ppa_c_in(ppa_c_in),
        .ppa_sum(ppa_sum), .ppa_c_out(ppa_c_out)
    );

    // Stand-in for the shared external adder.
    assign {ppa_c_out, ppa_sum} = 17'(ppa_add_1) + 17'(ppa_add_2) + 17'(ppa_c_in);

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            add1[16*i +: 16] = a[i];
            add2[16*i +: 16] = b[i];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner is the valid requester at the smallest round-robin distance past the last winner.
    function automatic int model_pick();
        int best = -1;
        int bd = NREQ + 1;
        for (int i = 0; i < NREQ; i++) begin
            int d;
            bit ok;
            ok = v[i];
`ifdef PPA_ARB_LOCK_EN
            if (m_locked && i != m_owner) ok = 0;
`endif
            d = (i - m_ptr - 1 + 2*NREQ) % NREQ;
            if (ok && d < bd) begin
                bd = d;
                best = i;
            end
        end
        return best;
    endfunction

    task automatic accept(input int g);
        logic        cc;
        logic [16:0] tot;
        cc = cin[g];
`ifdef PPA_ARB_LOCK_EN
        if (m_locked) cc = m_last_cout;
        m_lock_pend = lk[g];
        m_owner = g;
`endif
        tot = {1'b0, a[g]} + {1'b0, b[g]} + 17'(cc);
        m_last_cout = tot[16];
        exp_q.push_back('{g, tot});
        m_ptr = g;
        busy = 1;
    endtask

    task automatic cycle();
        int exp_g;
        int act_g;
        #1;
        exp_g = busy ? -1 : model_pick();
        chk("req_ready", 32'(req_ready), exp_g < 0 ? 32'd0 : (32'd1 << exp_g));
        act_g = -1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) act_g = i;
        if (act_g >= 0) grant_log.push_back(act_g);
        if (exp_g >= 0) accept(exp_g);
        @(negedge clk);
        if (exp_g >= 0) v[exp_g] = 1'b0;
    endtask

    task automatic drain();
        v = '0;
        rr = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (!busy) break;
            cycle();
        end
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 3))
            0: return 16'h0000;
            1: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    exp_t e;
    always @(negedge clk) begin
        #2;
        if (rst_n && rsp_valid && rr) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rsp: got id %0d sum %0h expected no response", rsp_id, rsp_sum);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_id", 32'(rsp_id), e.id);
                chk("rsp_sum", 32'(rsp_sum), 32'(e.res[15:0]));
                chk("rsp_c_out", 32'(rsp_c_out), 32'(e.res[16]));
            end
            busy = 0;
            m_locked = m_lock_pend;
        end
    end

    logic [16:0] dir_tab [4][4];
    int rr_exp [5];

    initial begin
        dir_tab = '{'{17'd4322, 17'd7656, 17'd1, 17'd11979},
                    '{17'd987,  17'd71,   17'd0, 17'd1058},
                    '{17'd65534, 17'd1,   17'd0, 17'd65535},
                    '{17'd65534, 17'd1,   17'd1, 17'h10000}};
        rr_exp = '{0, 1, 2, 3, 0};
        v = '0; cin = '0; lk = '0; rr = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a[i] = '0;
            b[i] = '0;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_sum", 32'(rsp_sum), 0);
        chk("reset_ppa_add_1", 32'(ppa_add_1), 0);
        rst_n = 1'b1;

        // Round robin from reset with everyone requesting.
        for (int i = 0; i < NREQ; i++) begin
            a[i] = rand_op();
            b[i] = rand_op();
        end
        v = '1;
        rr = 1'b1;
        grant_log.delete();
        for (int t = 0; t < 30 && grant_log.size() < 5; t++) begin
            cycle();
            v = '1;
        end
        for (int i = 0; i < 5; i++)
            chk("rr_order", i < grant_log.size() ? grant_log[i] : -1, rr_exp[i]);
        drain();

        // Directed sums on requester 1.
        for (int i = 0; i < 4; i++) begin
            v[1] = 1'b1;
            a[1] = dir_tab[i][0][15:0];
            b[1] = dir_tab[i][1][15:0];
            cin[1] = dir_tab[i][2][0];
            rr = 1'b0;
            cycle();
            cycle();
            chk("dir_valid", 32'(rsp_valid), 1);
            chk("dir_sum", 32'(rsp_sum), 32'(dir_tab[i][3][15:0]));
            chk("dir_cout", 32'(rsp_c_out), 32'(dir_tab[i][3][16]));
            chk("dir_id", 32'(rsp_id), 1);
            rr = 1'b1;
            cycle();
        end
        drain();

        // Backpressure: result held for 5 cycles while requester 0 waits.
        v[3] = 1'b1; a[3] = 16'h1234; b[3] = 16'h4321; cin[3] = 1'b1;
        rr = 1'b0;
        cycle();
        v[0] = 1'b1; a[0] = 16'h0F0F; b[0] = 16'h7000; cin[0] = 1'b0;
        cycle();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_sum", 32'(rsp_sum), 32'h5556);
            chk("bp_id", 32'(rsp_id), 3);
            cycle();
        end
        rr = 1'b1;
        cycle();
        rr = 1'b0;
        cycle();
        drain();

        // Reset during EXEC drops the operation.
        v[1] = 1'b1; a[1] = 16'hA5A5; b[1] = 16'h1111; cin[1] = 1'b1;
        rr = 1'b0;
        cycle();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_sum", 32'(rsp_sum), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_ppa_add_1", 32'(ppa_add_1), 0);
        chk("rst_ppa_add_2", 32'(ppa_add_2), 0);
        chk("rst_ppa_c_in", 32'(ppa_c_in), 0);
        exp_q.delete();
        busy = 0; m_ptr = NREQ - 1; m_locked = 0; m_lock_pend = 0;
        @(negedge clk);
        rst_n = 1'b1;
        v = 4'b0101;
        rr = 1'b1;
        grant_log.delete();
        cycle();
        chk("rst_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
        v[2] = 1'b0;
        drain();

`ifdef PPA_ARB_LOCK_EN
        // Two-word chain from requester 2 with requester 0 stalled.
        v[2] = 1'b1; a[2] = 16'hFFFF; b[2] = 16'h0001; cin[2] = 1'b0; lk[2] = 1'b1;
        rr = 1'b0;
        cycle();
        v[0] = 1'b1; a[0] = 16'h0005; b[0] = 16'h0006; lk[0] = 1'b0;
        cycle();
        chk("lock_sum1", 32'(rsp_sum), 0);
        chk("lock_cout1", 32'(rsp_c_out), 1);
        rr = 1'b1;
        cycle();
        rr = 1'b0;
        cycle();
        chk("lock_stall", 32'(req_ready), 0);
        v[2] = 1'b1; a[2] = 16'h0001; b[2] = 16'h0000; cin[2] = 1'b0; lk[2] = 1'b0;
        cycle();
        cycle();
        chk("lock_sum2", 32'(rsp_sum), 2);
        rr = 1'b1;
        cycle();
        grant_log.delete();
        cycle();
        chk("lock_release_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
        drain();
        lk = '0;
`endif

        // Randomized traffic.
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i] && $urandom_range(0, 3) == 0) begin
                    v[i] = 1'b1;
                    a[i] = rand_op();
                    b[i] = rand_op();
                    cin[i] = 1'($urandom_range(0, 1));
                    lk[i] = ($urandom_range(0, 2) == 0);
                end
            end
            rr = ($urandom_range(0, 2) != 0);
            cycle();
        end
        drain();
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
